mem_bus_master: RTL

MEM_BUS_MASTER -- requirements
Module: mem_bus_master

---
 rtl/mem_bus_master_if.sv | 41 ++++
 rtl/mem_bus_master.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_master_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_bus_master_if: request/response handshake and memory-side bus bundle.
// Rev 1.0
// ----------------------------------------------------------------------------
interface mem_bus_master_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic          rsp_write;
   logic [AW-1:0] rsp_addr;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          enable;
   logic          read;
   logic          write;
   logic [AW-1:0] raddr;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready, rdata,
      output req_ready, rsp_valid, rsp_write, rsp_addr, rsp_rdata, rsp_err,
      output enable, read, write, raddr, waddr, wdata
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready, rdata,
      input  req_ready, rsp_valid, rsp_write, rsp_addr, rsp_rdata, rsp_err,
      input  enable, read, write, raddr, waddr, wdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_bus_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_bus_master: queued single-outstanding memory master, in-order responses.
// Optional write read-back check: MEM_BUS_MASTER_RDBACK_EN.        Rev 1.0
// ----------------------------------------------------------------------------
module mem_bus_master #(
   parameter int FIFO_DEPTH = 4,
   parameter int AW         = 8,
   parameter int DW         = 8
) (
   input  logic             clk,
   input  logic             rst,
   mem_bus_master_if.master bus
);
   localparam int                 c_PTR_W   = $clog2(FIFO_DEPTH);
   localparam int                 c_EW      = 1 + AW + DW;
   localparam logic [c_PTR_W:0]   c_FULL    = (c_PTR_W+1)'(FIFO_DEPTH);
   localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W+1)'(1);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WR   = 3'd1,
      S_RD   = 3'd2,
      S_WAIT = 3'd3,
`ifdef MEM_BUS_MASTER_RDBACK_EN
      S_RB   = 3'd5,
`endif
      S_RSP  = 3'd4
   } state_t;

   state_t              r_state;
   logic [c_EW-1:0]     r_fifo [FIFO_DEPTH];
   logic [c_PTR_W-1:0]  r_wptr;
   logic [c_PTR_W-1:0]  r_rptr;
   logic [c_PTR_W:0]    r_count;
   logic                r_write;
   logic [AW-1:0]       r_addr;
   logic                r_enable;
   logic                r_mem_rd;
   logic                r_mem_wr;
   logic [AW-1:0]       r_raddr;
   logic [AW-1:0]       r_waddr;
   logic [DW-1:0]       r_wdata;
   logic                r_rsp_valid;
   logic                r_rsp_write;
   logic [AW-1:0]       r_rsp_addr;
   logic [DW-1:0]       r_rsp_rdata;

   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic [c_EW-1:0]     w_head;
   logic                w_head_write;
   logic [AW-1:0]       w_head_addr;
   logic [DW-1:0]       w_head_data;

   assign w_full       = (r_count == c_FULL);
   assign w_empty      = (r_count == '0);
   assign w_push       = bus.req_valid && bus.req_ready;
   assign w_pop        = (r_state == S_IDLE) && !w_empty;
   assign w_head       = r_fifo[r_rptr];
   assign w_head_write = w_head[c_EW-1];
   assign w_head_addr  = w_head[AW+DW-1:DW];
   assign w_head_data  = w_head[DW-1:0];

   // Storage needs no reset: an entry is only read after it has been pushed.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wptr] <= {bus.req_write, bus.req_addr, bus.req_wdata};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + c_PTR_ONE;
         if (w_pop)  r_rptr <= r_rptr + c_PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef MEM_BUS_MASTER_RDBACK_EN
   logic r_rsp_err;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_write     <= 1'b0;
         r_addr      <= '0;
         r_enable    <= 1'b0;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_raddr     <= '0;
         r_waddr     <= '0;
         r_wdata     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_write <= 1'b0;
         r_rsp_addr  <= '0;
         r_rsp_rdata <= '0;
`ifdef MEM_BUS_MASTER_RDBACK_EN
         r_rsp_err   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_write  <= w_head_write;
                  r_addr   <= w_head_addr;
                  r_enable <= 1'b1;
                  if (w_head_write) begin
                     r_mem_wr <= 1'b1;
                     r_waddr  <= w_head_addr;
                     r_wdata  <= w_head_data;
                     r_state  <= S_WR;
                  end else begin
                     r_mem_rd <= 1'b1;
                     r_raddr  <= w_head_addr;
                     r_state  <= S_RD;
                  end
               end
            end
            S_WR: begin
               r_mem_wr <= 1'b0;
`ifdef MEM_BUS_MASTER_RDBACK_EN
               r_mem_rd <= 1'b1;
               r_raddr  <= r_waddr;
               r_state  <= S_RB;
`else
               r_enable    <= 1'b0;
               r_rsp_valid <= 1'b1;
               r_rsp_write <= 1'b1;
               r_rsp_addr  <= r_addr;
               r_rsp_rdata <= '0;
               r_state     <= S_RSP;
`endif
            end
`ifdef MEM_BUS_MASTER_RDBACK_EN
            S_RB: begin
               r_enable <= 1'b0;
               r_mem_rd <= 1'b0;
               r_state  <= S_WAIT;
            end
`endif
            S_RD: begin
               r_enable <= 1'b0;
               r_mem_rd <= 1'b0;
               r_state  <= S_WAIT;
            end
            S_WAIT: begin
               // rdata here is the memory's registered reply to the previous read strobe.
               r_rsp_valid <= 1'b1;
               r_rsp_write <= r_write;
               r_rsp_addr  <= r_addr;
               r_rsp_rdata <= bus.rdata;
`ifdef MEM_BUS_MASTER_RDBACK_EN
               r_rsp_err   <= r_write && (bus.rdata != r_wdata);
`endif
               r_state     <= S_RSP;
            end
            S_RSP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready = !rst && !w_full;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_write = r_rsp_write;
   assign bus.rsp_addr  = r_rsp_addr;
   assign bus.rsp_rdata = r_rsp_rdata;
`ifdef MEM_BUS_MASTER_RDBACK_EN
   assign bus.rsp_err   = r_rsp_err;
`else
   assign bus.rsp_err   = 1'b0;
`endif
   assign bus.enable    = r_enable;
   assign bus.read      = r_mem_rd;
   assign bus.write     = r_mem_wr;
   assign bus.raddr     = r_raddr;
   assign bus.waddr     = r_waddr;
   assign bus.wdata     = r_wdata;
endmodule
`default_nettype wire
